// File: rtl/msk_gf2n_mul_hpc1_pipe.sv
// d-share masked GF(2^n) multiplier (HPC1): refresh of operand b, then DOM cross products.
// Two-stage valid/ready pipeline with a per-transaction squaring mode.
module msk_gf2n_mul_hpc1_pipe #(
  parameter int d = 2,
  parameter int n = 4,
  parameter logic [n-1:0] POLY = 'h3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sq,
  input  logic [n*d-1:0]              ina,
  input  logic [n*d-1:0]              inb,
  input  logic [n*d*(d-1)/2-1:0]      rnd_ref,
  input  logic [n*d*(d-1)/2-1:0]      rnd_mul,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [n*d-1:0]              out
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // The whole pipe advances together whenever the output slot is empty or being drained,
  // so in_ready does not depend on in_valid and every register holds while stalled.
  logic adv;
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;

  function automatic logic [n-1:0] gf_mul(input logic [n-1:0] x, input logic [n-1:0] y);
    logic [n-1:0] acc;
    logic [n-1:0] sh;
    acc = '0;
    sh  = x;
    for (int k = 0; k < n; k++) begin
      if (y[k]) acc = acc ^ sh;
      sh = sh[n-1] ? ((sh << 1) ^ POLY) : (sh << 1);
    end
    return acc;
  endfunction

  // Share pairs (i<j) are numbered in lexicographic order for both randomness buses.
  function automatic int pair_idx(input int i, input int j);
    return i * d - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  logic [n-1:0] a_sh  [d];
  logic [n-1:0] b_ref [d];
  logic [n-1:0] a_q   [d];
  logic [n-1:0] b_q   [d];
  logic         sq_q;
  logic         v1;
  logic [n-1:0] p_d   [d][d];
  logic [n-1:0] p_q   [d][d];
  logic         v2;

  always_comb begin
    for (int k = 0; k < d; k++) begin
      a_sh[k]  = ina[k*n +: n];
      b_ref[k] = inb[k*n +: n];
    end
    for (int i = 0; i < d; i++) begin
      for (int j = i + 1; j < d; j++) begin
        b_ref[i] = b_ref[i] ^ rnd_ref[pair_idx(i, j)*n +: n];
        b_ref[j] = b_ref[j] ^ rnd_ref[pair_idx(i, j)*n +: n];
      end
    end
  end

  // Squaring is linear, so each share squares alone and no cross term or mask is needed.
  always_comb begin
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        p_d[i][j] = '0;
      end
    end
    for (int i = 0; i < d; i++) begin
      p_d[i][i] = sq_q ? gf_mul(a_q[i], a_q[i]) : gf_mul(a_q[i], b_q[i]);
      for (int j = i + 1; j < d; j++) begin
        if (!sq_q) begin
          p_d[i][j] = gf_mul(a_q[i], b_q[j]) ^ rnd_mul[pair_idx(i, j)*n +: n];
          p_d[j][i] = gf_mul(a_q[j], b_q[i]) ^ rnd_mul[pair_idx(i, j)*n +: n];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      sq_q <= 1'b0;
      for (int k = 0; k < d; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int i = 0; i < d; i++) begin
        for (int j = 0; j < d; j++) begin
          p_q[i][j] <= '0;
        end
      end
    end else if (adv) begin
      v1   <= in_valid;
      v2   <= v1;
      sq_q <= in_sq;
      for (int k = 0; k < d; k++) begin
        a_q[k] <= a_sh[k];
        b_q[k] <= b_ref[k];
      end
      // Every partial product gets its own register before compression.
      for (int i = 0; i < d; i++) begin
        for (int j = 0; j < d; j++) begin
          p_q[i][j] <= p_d[i][j];
        end
      end
    end
  end

  always_comb begin
    out = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        out[i*n +: n] = out[i*n +: n] ^ p_q[i][j];
      end
    end
  end

  assign out_valid = v2;

endmodule

// File: tb/tb_msk_gf2n_mul_hpc1_pipe.sv
// Directed bench for the masked GF(2^n) multiplier: a d=2/n=4 instance and a d=3/n=8 AES-field instance.
module tb_msk_gf2n_mul_hpc1_pipe;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        v4, rdy4, sq4, ov4, or4;
  logic [7:0]  a4, b4, o4;
  logic [3:0]  rr4, rm4;
  logic        v8, rdy8, sq8, ov8, or8;
  logic [23:0] a8, b8, o8;
  logic [23:0] rr8, rm8;

  msk_gf2n_mul_hpc1_pipe #(.d(2), .n(4), .POLY(4'h3)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_sq(sq4),
    .ina(a4), .inb(b4), .rnd_ref(rr4), .rnd_mul(rm4),
    .out_valid(ov4), .out_ready(or4), .out(o4)
  );

  msk_gf2n_mul_hpc1_pipe #(.d(3), .n(8), .POLY(8'h1B)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_sq(sq8),
    .ina(a8), .inb(b8), .rnd_ref(rr8), .rnd_mul(rm8),
    .out_valid(ov8), .out_ready(or8), .out(o8)
  );

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp4_q[$];
  logic [7:0] exp8_q[$];
  logic [7:0] exp4_cur, exp8_cur;
  int         out_cnt4 = 0;
  int         out_cnt8 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b,
                                        input int nb, input logic [7:0] poly);
    logic [15:0] prod;
    logic [15:0] m;
    prod = '0;
    m    = {8'h00, poly} | (16'd1 << nb);
    for (int i = 0; i < nb; i++) if (b[i]) prod = prod ^ ({8'h00, a} << i);
    for (int k = 2*nb-2; k >= nb; k--) if (prod[k]) prod = prod ^ (m << (k - nb));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] unmask4(input logic [7:0] o);
    return {4'h0, o[3:0] ^ o[7:4]};
  endfunction

  function automatic logic [7:0] unmask8(input logic [23:0] o);
    return o[7:0] ^ o[15:8] ^ o[23:16];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    rr4 = 4'($urandom());
    rm4 = 4'($urandom());
    rr8 = 24'($urandom());
    rm8 = 24'($urandom());
  endtask

  task automatic drive4(input logic sq, input logic [3:0] a, input logic [3:0] b, input logic [3:0] e);
    logic [3:0] r;
    r  = 4'($urandom());
    a4 = {r, a ^ r};
    r  = 4'($urandom());
    b4 = {r, b ^ r};
    sq4 = sq;
    v4  = 1'b1;
    exp4_cur = {4'h0, e};
  endtask

  task automatic drive8(input logic sq, input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    logic [7:0] r1, r2;
    r1 = 8'($urandom());
    r2 = 8'($urandom());
    a8 = {r2, r1, a ^ r1 ^ r2};
    r1 = 8'($urandom());
    r2 = 8'($urandom());
    b8 = {r2, r1, b ^ r1 ^ r2};
    sq8 = sq;
    v8  = 1'b1;
    exp8_cur = e;
  endtask

  // ---------------- monitor: push on input handshake, pop on output handshake ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp4_q.delete();
      exp8_q.delete();
    end else begin
      if (v4 && rdy4) exp4_q.push_back(exp4_cur);
      if (v8 && rdy8) exp8_q.push_back(exp8_cur);
      if (ov4 && or4) begin
        out_cnt4++;
        check("sb4_nonempty", 32'(exp4_q.size() != 0), 32'd1);
        if (exp4_q.size() != 0) check("sb4_data", 32'(unmask4(o4)), 32'(exp4_q.pop_front()));
      end
      if (ov8 && or8) begin
        out_cnt8++;
        check("sb8_nonempty", 32'(exp8_q.size() != 0), 32'd1);
        if (exp8_q.size() != 0) check("sb8_data", 32'(unmask8(o8)), 32'(exp8_q.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [3:0] bp_a [4];
  logic [3:0] bp_b [4];
  logic [3:0] bp_e [4];
  logic       mx_sq [6];
  logic [3:0] mx_a [6];
  logic [3:0] mx_b [6];
  logic [3:0] mx_e [6];
  logic [7:0] hold;
  logic [3:0] t2_a0, t2_a1;
  logic [7:0] ra, rb, re;
  logic       rs;
  int         idx, cnt0;

  initial begin
    bp_a = '{4'h2, 4'h4, 4'hF, 4'h8};
    bp_b = '{4'h3, 4'h4, 4'h1, 4'h8};
    bp_e = '{4'h6, 4'h3, 4'hF, 4'hC};
    mx_sq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    mx_a  = '{4'h3, 4'h3, 4'h6, 4'hF, 4'hA, 4'h2};
    mx_b  = '{4'h7, 4'h0, 4'h5, 4'h0, 4'hB, 4'h0};
    mx_e  = '{4'h9, 4'h5, 4'hD, 4'hA, 4'h2, 4'h4};

    rst = 1'b1;
    v4 = 0; sq4 = 0; a4 = '0; b4 = '0; rr4 = '0; rm4 = '0; or4 = 1'b1;
    v8 = 0; sq8 = 0; a8 = '0; b8 = '0; rr8 = '0; rm8 = '0; or8 = 1'b1;
    exp4_cur = '0; exp8_cur = '0; hold = '0;
    repeat (2) step();

    // reset state
    check("rst_ov4", 32'(ov4), 32'd0);
    check("rst_out4", 32'(o4), 32'd0);
    check("rst_ov8", 32'(ov8), 32'd0);
    check("rst_out8", 32'(o8), 32'd0);
    check("rst_rdy4", 32'(rdy4), 32'd1);
    rst = 1'b0;

    // 1: 3*7 = 9, latency 2
    step();
    drive4(1'b0, 4'h3, 4'h7, 4'h9);
    step(); v4 = 1'b0;
    check("t1_lat1_ov", 32'(ov4), 32'd0);
    step();
    check("t1_ov", 32'(ov4), 32'd1);
    check("t1_val", 32'(unmask4(o4)), 32'h9);
    step();
    check("t1_ov_low", 32'(ov4), 32'd0);

    // 2: square of 8 = 0xC, b garbage, each output share is the square of its own a share
    drive4(1'b1, 4'h8, 4'($urandom()), 4'hC);
    t2_a0 = a4[3:0];
    t2_a1 = a4[7:4];
    step(); v4 = 1'b0;
    step();
    check("t2_ov", 32'(ov4), 32'd1);
    check("t2_val", 32'(unmask4(o4)), 32'hC);
    check("t2_share0", 32'(o4[3:0]), 32'(gf_ref({4'h0, t2_a0}, {4'h0, t2_a0}, 4, 8'h03)));
    check("t2_share1", 32'(o4[7:4]), 32'(gf_ref({4'h0, t2_a1}, {4'h0, t2_a1}, 4, 8'h03)));
    step();

    // 4: stream 4 transactions, out_ready low for 3 cycles
    idx  = 0;
    cnt0 = out_cnt4;
    for (int k = 0; k < 12; k++) begin
      or4 = !(k >= 3 && k <= 5);
      if (idx < 4) drive4(1'b0, bp_a[idx], bp_b[idx], bp_e[idx]);
      else v4 = 1'b0;
      #1;
      if (k >= 3 && k <= 5) begin
        check("t4_stall_rdy", 32'(rdy4), 32'd0);
        check("t4_stall_ov", 32'(ov4), 32'd1);
        if (k == 3) hold = o4;
        else check("t4_hold", 32'(o4), 32'(hold));
      end
      if (v4 && rdy4) idx++;
      step();
    end
    or4 = 1'b1;
    check("t4_count", 32'(out_cnt4 - cnt0), 32'd4);
    check("t4_drained", 32'(exp4_q.size()), 32'd0);

    // 5: reset with two transactions in flight
    drive4(1'b0, 4'h3, 4'h7, 4'h9);
    step();
    drive4(1'b0, 4'h2, 4'h3, 4'h6);
    step(); v4 = 1'b0;
    check("t5_pre_ov", 32'(ov4), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_ov", 32'(ov4), 32'd0);
    check("t5_rst_out", 32'(o4), 32'd0);
    step(); rst = 1'b0;
    check("t5_post_ov", 32'(ov4), 32'd0);
    check("t5_post_out", 32'(o4), 32'd0);
    drive4(1'b0, 4'hA, 4'hB, 4'h2);
    step(); v4 = 1'b0;
    check("t5_lat1_ov", 32'(ov4), 32'd0);
    step();
    check("t5_ov", 32'(ov4), 32'd1);
    check("t5_val", 32'(unmask4(o4)), 32'h2);
    step();
    check("t5_ov_low", 32'(ov4), 32'd0);

    // 6: back-to-back mixed multiply / square
    cnt0 = out_cnt4;
    for (int i = 0; i < 6; i++) begin
      drive4(mx_sq[i], mx_a[i], mx_sq[i] ? 4'($urandom()) : mx_b[i], mx_e[i]);
      step();
    end
    v4 = 1'b0;
    repeat (3) step();
    check("t6_count", 32'(out_cnt4 - cnt0), 32'd6);
    check("t6_drained", 32'(exp4_q.size()), 32'd0);

    // 3: AES field, d=3
    drive8(1'b0, 8'h57, 8'h83, 8'hC1);
    step(); v8 = 1'b0;
    check("t3_lat1_ov", 32'(ov8), 32'd0);
    step();
    check("t3_ov", 32'(ov8), 32'd1);
    check("t3_val", 32'(unmask8(o8)), 32'hC1);
    step();
    drive8(1'b0, 8'h02, 8'h87, 8'h15);
    step(); v8 = 1'b0;
    step();
    check("t3_xtime", 32'(unmask8(o8)), 32'h15);
    step();
    cnt0 = out_cnt8;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom());
      rb = 8'($urandom());
      rs = ($urandom_range(0, 3) == 0);
      re = rs ? gf_ref(ra, ra, 8, 8'h1B) : gf_ref(ra, rb, 8, 8'h1B);
      drive8(rs, ra, rb, re);
      step();
    end
    v8 = 1'b0;
    repeat (3) step();
    check("t3_count", 32'(out_cnt8 - cnt0), 32'd1000);
    check("t3_drained", 32'(exp8_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
